// File: rtl/fifo_pkg.sv
// Shared constants and types for the asynchronous FIFO and its read-side streamer.
package fifo_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 16;
    localparam int unsigned DEF_CNT_W = 16;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    // Words that will be held after this edge: buffered + landing - leaving.
    function automatic logic [2:0] credit_after(input occ_t occ, input logic inflight, input logic pop);
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fifo_read_streamer_chk.sv
// Protocol checks for the read streamer: no buffer overflow, no read of an empty FIFO.
module fifo_read_streamer_chk
    import fifo_pkg::*;
(
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input occ_t occ,
    input logic fifo_empty,
    input logic fifo_r_en
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (occ == OCC_FULL)));

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        (occ != 2'd3));

    a_no_empty_read: assert property (@(posedge clk) disable iff (rst)
        !(fifo_r_en && fifo_empty));

endmodule

// File: rtl/stream_skid_buf2.sv
// Two-entry in-order register buffer; entry0 is always the head word.
module stream_skid_buf2
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output occ_t             occ,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] entry0_r;
    logic [WIDTH-1:0] entry1_r;
    logic             pop_ok_s;

    assign pop_ok_s  = pop && (occ != OCC_EMPTY);
    assign head_data = entry0_r;

    // Occupancy and storage update; a push into a full buffer is dropped and flagged by the checker.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= OCC_EMPTY;
            entry0_r <= '0;
            entry1_r <= '0;
        end else begin
            case ({push, pop_ok_s})
                2'b10: begin
                    if (occ == OCC_EMPTY) begin
                        entry0_r <= push_data;
                        occ      <= OCC_ONE;
                    end else if (occ == OCC_ONE) begin
                        entry1_r <= push_data;
                        occ      <= OCC_FULL;
                    end
                end
                2'b01: begin
                    entry0_r <= entry1_r;
                    occ      <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == OCC_FULL) begin
                        entry0_r <= entry1_r;
                        entry1_r <= push_data;
                    end else begin
                        entry0_r <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_read_streamer.sv
// Read-domain consumer of the async FIFO: issues r_en against a credit budget and
// streams popped words downstream through a 2-entry buffer.
module fifo_read_streamer
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             r_clk,
    input  logic             r_rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_r_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] rd_count
);

    occ_t             occ_s;
    logic             inflight_r;
    logic             pop_s;
    logic [2:0]       credit_s;
    logic [CNT_W-1:0] rd_count_r;

    assign m_valid  = (occ_s != OCC_EMPTY);
    assign pop_s    = m_valid && m_ready;
    assign rd_count = rd_count_r;

    // Issue a read only if the word it returns is guaranteed a buffer slot.
    always_comb begin
        credit_s = credit_after(occ_s, inflight_r, pop_s);
        if (r_rst || fifo_empty) begin
            fifo_r_en = 1'b0;
        end else begin
            fifo_r_en = (credit_s < 3'd2);
        end
    end

    // Track the word returning from the FIFO's one-cycle read latency.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= fifo_r_en;
        end
    end

    // Delivered-word counter, wraps naturally.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            rd_count_r <= '0;
        end else if (pop_s) begin
            rd_count_r <= rd_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    stream_skid_buf2 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (r_clk),
        .rst       (r_rst),
        .push      (inflight_r),
        .push_data (fifo_data),
        .pop       (pop_s),
        .occ       (occ_s),
        .head_data (m_data)
    );

    fifo_read_streamer_chk u_chk (
        .clk        (r_clk),
        .rst        (r_rst),
        .push       (inflight_r),
        .pop        (pop_s),
        .occ        (occ_s),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en)
    );

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Bench for fifo_read_streamer: queue-based FIFO model, word-count reference model,
// a directed vector table and hand-written corner sequences.
module tb_fifo_read_streamer;

    logic       r_clk = 1'b0;
    logic       r_rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_r_en;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
    logic [3:0] rd_count;

    fifo_read_streamer #(.WIDTH(8), .CNT_W(4)) dut (
        .r_clk      (r_clk),
        .r_rst      (r_rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .rd_count   (rd_count)
    );

    always #5 r_clk = ~r_clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] fq[$];      // FIFO contents
    logic [7:0] exp_q[$];   // words popped from the FIFO, not yet delivered
    int         inflight_m = 0;
    logic [3:0] exp_cnt = 4'd0;
    logic       hold_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       checking = 1'b0;
    int         cyc = 0;
    int         hs_count = 0;
    int         first_hs_cyc = 0;
    int         last_hs_cyc = 0;
    logic [7:0] first_hs_data = 8'h00;

    logic       s_ren, s_valid;
    logic [7:0] s_data;
    logic [3:0] s_cnt;

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rdy;
        logic       e_ren;
        logic       e_valid;
        logic [7:0] e_data;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: apply inputs, sample mid-cycle, check against the model, advance the model.
    task automatic step(input logic rst, input logic wr, input logic [7:0] wd, input logic rdy);
        int   occ_m;
        logic exp_valid, exp_pop, exp_ren, fpop;
        logic [7:0] w;
        if (wr) fq.push_back(wd);
        r_rst = rst;
        m_ready = rdy;
        fifo_empty = (fq.size() == 0);
        @(negedge r_clk);
        s_ren = fifo_r_en;
        s_valid = m_valid;
        s_data = m_data;
        s_cnt = rd_count;
        occ_m = exp_q.size() - inflight_m;
        exp_valid = (occ_m != 0);
        exp_pop = exp_valid && rdy;
        exp_ren = !rst && !fifo_empty && ((exp_q.size() - (exp_pop ? 1 : 0)) < 2);
        if (checking) begin
            chk("r_en", {31'd0, s_ren}, {31'd0, exp_ren});
            chk("m_valid", {31'd0, s_valid}, {31'd0, exp_valid});
            if (exp_valid) chk("m_data", {24'd0, s_data}, {24'd0, exp_q[0]});
            chk("rd_count", {28'd0, s_cnt}, {28'd0, exp_cnt});
            if (hold_prev && s_valid) chk("m_data_hold", {24'd0, s_data}, {24'd0, prev_data});
        end
        if (s_valid && rdy) begin
            if (hs_count == 0) begin
                first_hs_data = s_data;
                first_hs_cyc = cyc;
            end
            hs_count++;
            last_hs_cyc = cyc;
        end
        fpop = s_ren && !fifo_empty;
        hold_prev = exp_valid && !rdy && !rst;
        prev_data = s_data;
        @(posedge r_clk);
        #1;
        cyc++;
        if (rst) begin
            fq.delete();
            exp_q.delete();
            inflight_m = 0;
            exp_cnt = 4'd0;
            hold_prev = 1'b0;
        end else begin
            if (exp_pop) begin
                void'(exp_q.pop_front());
                exp_cnt = exp_cnt + 4'd1;
            end
            if (fpop) begin
                w = fq.pop_front();
                exp_q.push_back(w);
                fifo_data = w;
            end
            inflight_m = fpop ? 1 : 0;
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        hs_count = 0;
    endtask

    task automatic preload(input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) fq.push_back(base + k[7:0]);
    endtask

    initial begin
        int start;
        //          wr    wd     rdy   ren   valid data   cnt
        vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0};
        vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0};
        vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h11, 4'd0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 4'd1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 4'd2};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd3};
        vecs[6]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 8'h00, 4'd3};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd3};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 4'd3};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44, 4'd3};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd4};

        // Power-on reset, then a checked reset cycle.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        checking = 1'b1;
        do_reset();
        chk("rst_m_data", {24'd0, s_data}, 32'd0);
        chk("rst_m_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_r_en", {31'd0, s_ren}, 32'd0);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            step(1'b0, vecs[i].wr, vecs[i].wd, vecs[i].rdy);
            chk($sformatf("tbl%0d_ren", i), {31'd0, s_ren}, {31'd0, vecs[i].e_ren});
            chk($sformatf("tbl%0d_valid", i), {31'd0, s_valid}, {31'd0, vecs[i].e_valid});
            if (vecs[i].e_valid) chk($sformatf("tbl%0d_data", i), {24'd0, s_data}, {24'd0, vecs[i].e_data});
            chk($sformatf("tbl%0d_cnt", i), {28'd0, s_cnt}, {28'd0, vecs[i].e_cnt});
        end

        // Eight-word burst: back-to-back after two cycles of latency.
        do_reset();
        preload(8, 8'h00);
        start = cyc;
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("burst_count", hs_count, 32'd8);
        chk("burst_first", first_hs_cyc, start + 2);
        chk("burst_last", last_hs_cyc, start + 9);

        // Ten-cycle stall: head held, no reads while the buffer is saturated.
        do_reset();
        preload(8, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            if (i >= 2) begin
                chk("stall_ren", {31'd0, s_ren}, 32'd0);
                chk("stall_valid", {31'd0, s_valid}, 32'd1);
                chk("stall_data", {24'd0, s_data}, 32'h00);
            end
        end
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("stall_count", hs_count, 32'd8);
        chk("stall_first", {24'd0, first_hs_data}, 32'h00);

        // Alternating ready over a sixteen-word stream.
        do_reset();
        preload(16, 8'h40);
        for (int i = 0; i < 44; i++) step(1'b0, 1'b0, 8'h00, (i % 2) == 0);
        chk("toggle_count", hs_count, 32'd16);
        chk("toggle_rd_count", {28'd0, s_cnt}, 32'd0);
        chk("toggle_drained", exp_q.size(), 32'd0);

        // Reset mid-stream, then a fresh word comes through first.
        do_reset();
        preload(8, 8'h80);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("mid_rst_valid", {31'd0, s_valid}, 32'd0);
        chk("mid_rst_cnt", {28'd0, s_cnt}, 32'd0);
        chk("mid_rst_ren", {31'd0, s_ren}, 32'd0);
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("mid_rst_count", hs_count, 32'd1);
        chk("mid_rst_word", {24'd0, first_hs_data}, 32'hA5);

        // Counter wrap with a 4-bit counter: 18 words leave rd_count at 2.
        do_reset();
        preload(18, 8'hC0);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("wrap_count", hs_count, 32'd18);
        chk("wrap_rd_count", {28'd0, s_cnt}, 32'd2);

        // Randomized traffic with occasional resets, then drain.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 150) == 0, ($urandom % 3) != 0, 8'($urandom), ($urandom % 4) != 0);
        end
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("rand_drained", exp_q.size() + fq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
